// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the two MEM-stage slots, the single-port data memory and the arbiter.
// No latency of its own.
// Backpressure: the arbiter's stall output freezes the slot inputs.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              rd1;
    logic              wr1;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              rd2;
    logic              wr2;
    logic [DATA_W-1:0] addr2;
    logic [DATA_W-1:0] wdata2;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              stall;
    logic [15:0]       conflict_cnt;

    // Pipeline/memory side
    modport master (
        output rd1, wr1, addr1, wdata1, rd2, wr2, addr2, wdata2, mem_rdata,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata, rdata1, rdata2, stall, conflict_cnt
    );

    // Arbiter side
    modport slave (
        input  rd1, wr1, addr1, wdata1, rd2, wr2, addr2, wdata2, mem_rdata,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata, rdata1, rdata2, stall, conflict_cnt
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between two MEM-stage slots, slot 1 first.
// Latency: 0 cycles for a single access, one stall cycle per dual access.
// Backpressure: stall high freezes the pipeline; optional DMEM_ARB_PERF_CNT_EN enables conflict_cnt.
module dmem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, SECOND} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] hold1_q;

    logic              req1;
    logic              req2;
    logic              ld1;
    logic              ld2;
    logic              drive;
    logic              sel2;
    logic              stall_c;
    logic              rd_en_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] rdata1_c;
    logic [DATA_W-1:0] rdata2_c;
    logic              conflict;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^{bus.addr1[DATA_W-1:ADDR_W], bus.addr2[DATA_W-1:ADDR_W]};

    // A slot with both rd and wr set is a store
    assign req1 = bus.rd1 | bus.wr1;
    assign req2 = bus.rd2 | bus.wr2;
    assign ld1  = bus.rd1 & ~bus.wr1;
    assign ld2  = bus.rd2 & ~bus.wr2;

    always_comb begin
        state_d  = state_q;
        drive    = 1'b0;
        sel2     = 1'b0;
        stall_c  = 1'b0;
        rd_en_c  = 1'b0;
        wr_en_c  = 1'b0;
        addr_c   = '0;
        wdata_c  = '0;
        rdata1_c = '0;
        rdata2_c = '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (req1) begin
                        drive    = 1'b1;
                        rdata1_c = ld1 ? bus.mem_rdata : '0;
                        if (req2) begin
                            stall_c = 1'b1;
                            state_d = SECOND;
                        end
                    end else if (req2) begin
                        drive    = 1'b1;
                        sel2     = 1'b1;
                        rdata2_c = ld2 ? bus.mem_rdata : '0;
                    end
                end
                SECOND: begin
                    drive    = 1'b1;
                    sel2     = 1'b1;
                    rdata1_c = hold1_q;
                    rdata2_c = bus.mem_rdata;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        if (drive) begin
            if (sel2) begin
                rd_en_c = ld2;
                wr_en_c = bus.wr2;
                addr_c  = bus.addr2[ADDR_W-1:0];
                wdata_c = bus.wr2 ? bus.wdata2 : '0;
            end else begin
                rd_en_c = ld1;
                wr_en_c = bus.wr1;
                addr_c  = bus.addr1[ADDR_W-1:0];
                wdata_c = bus.wr1 ? bus.wdata1 : '0;
            end
        end
    end

    assign conflict = (state_q == IDLE) && (state_d == SECOND);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            hold1_q <= '0;
        end else begin
            state_q <= state_d;
            // A store in slot 1 leaves nothing to return, so hold1 reads back as 0
            if (conflict) hold1_q <= ld1 ? bus.mem_rdata : '0;
        end
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (conflict && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
    assign bus.conflict_cnt = rst ? cnt_q : 16'd0;
`else
    assign bus.conflict_cnt = 16'd0;
`endif

    assign bus.stall     = stall_c;
    assign bus.mem_rd_en = rd_en_c;
    assign bus.mem_wr_en = wr_en_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.rdata1    = rdata1_c;
    assign bus.rdata2    = rdata2_c;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-port memory and a per-cycle scoreboard.
module tb_dmem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dmem_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:1023];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;

    typedef struct {
        logic        stall;
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          step   = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step, got, want);
        end
    endtask

    task automatic set1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.rd1 = rd; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic set2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.rd2 = rd; bus.wr2 = wr; bus.addr2 = a; bus.wdata2 = d;
    endtask

    // Push the expectation for the current cycle, compare mid-cycle, then advance one edge
    task automatic cyc(input logic st, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [31:0] wd, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        e.stall = st; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd; e.r1 = r1; e.r2 = r2;
        e.cnt = rst ? exp_cnt : 16'd0;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("stall",  {31'd0, bus.stall},     {31'd0, e.stall});
        chk("rd_en",  {31'd0, bus.mem_rd_en}, {31'd0, e.rd});
        chk("wr_en",  {31'd0, bus.mem_wr_en}, {31'd0, e.wr});
        chk("addr",   {22'd0, bus.mem_addr},  {22'd0, e.addr});
        chk("wdata",  bus.mem_wdata, e.wdata);
        chk("rdata1", bus.rdata1,    e.r1);
        chk("rdata2", bus.rdata2,    e.r2);
        chk("cnt",    {16'd0, bus.conflict_cnt}, {16'd0, e.cnt});
        if (!rst) exp_cnt = 16'd0;
`ifdef DMEM_ARB_PERF_CNT_EN
        else if (st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        @(posedge clk);
        #1;
        step++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[5] = 32'hA5;
        mem[3] = 32'd11;
        mem[4] = 32'd22;
        set1(1'b1, 1'b0, 32'd5, 32'd0);
        set2(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset held: outputs forced to 0 even with a request present
        cyc(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 32'd0);
        rst = 1'b1;
        set1(1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 32'd0);

        // Single load slot 1 (upper address bits ignored)
        set1(1'b1, 1'b0, 32'hFFFF_FC05, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 10'd5, 32'd0, 32'hA5, 32'd0);

        // Single load slot 2
        set1(1'b0, 1'b0, 32'd0, 32'd0);
        set2(1'b1, 1'b0, 32'd3, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 10'd3, 32'd0, 32'd0, 32'd11);

        // Single store slot 2
        set2(1'b0, 1'b1, 32'd20, 32'd77);
        cyc(1'b0, 1'b0, 1'b1, 10'd20, 32'd77, 32'd0, 32'd0);
        chk("mem20", mem[20], 32'd77);

        // Dual loads
        set1(1'b1, 1'b0, 32'd3, 32'd0);
        set2(1'b1, 1'b0, 32'd4, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 10'd3, 32'd0, 32'd11, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 10'd4, 32'd0, 32'd11, 32'd22);

        // Store then load to the same address
        set1(1'b0, 1'b1, 32'd7, 32'hDEAD);
        set2(1'b1, 1'b0, 32'd7, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 10'd7, 32'hDEAD, 32'd0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 10'd7, 32'd0, 32'd0, 32'hDEAD);

        // Dual stores to the same address: slot 2 wins
        set1(1'b0, 1'b1, 32'd9, 32'd1);
        set2(1'b0, 1'b1, 32'd9, 32'd2);
        cyc(1'b1, 1'b0, 1'b1, 10'd9, 32'd1, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 10'd9, 32'd2, 32'd0, 32'd1);
        chk("mem9", mem[9], 32'd2);

        // rd and wr together on one slot act as a store
        set1(1'b1, 1'b1, 32'd30, 32'd5);
        set2(1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 10'd30, 32'd5, 32'd0, 32'd0);
        chk("mem30", mem[30], 32'd5);

        // Back-to-back dual loads: stall 1,0,1,0
        set1(1'b1, 1'b0, 32'd3, 32'd0);
        set2(1'b1, 1'b0, 32'd4, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 10'd3, 32'd0, 32'd11, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 10'd4, 32'd0, 32'd11, 32'd22);
        cyc(1'b1, 1'b1, 1'b0, 10'd3, 32'd0, 32'd11, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 10'd4, 32'd0, 32'd11, 32'd22);

        // Reset during SECOND drops the pending slot-2 store
        set1(1'b0, 1'b1, 32'd40, 32'd8);
        set2(1'b0, 1'b1, 32'd40, 32'd9);
        cyc(1'b1, 1'b0, 1'b1, 10'd40, 32'd8, 32'd0, 32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 32'd0);
        chk("mem40", mem[40], 32'd8);
        rst = 1'b1;
        set1(1'b0, 1'b0, 32'd0, 32'd0);
        set2(1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 32'd0);

        // Back in IDLE: a single load completes without stalling
        set1(1'b1, 1'b0, 32'd5, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 10'd5, 32'd0, 32'hA5, 32'd0);

        // Three dual accesses after reset
        set2(1'b1, 1'b0, 32'd4, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 10'd5, 32'd0, 32'hA5, 32'd0);
            cyc(1'b0, 1'b1, 1'b0, 10'd4, 32'd0, 32'hA5, 32'd22);
        end
        set1(1'b0, 1'b0, 32'd0, 32'd0);
        set2(1'b0, 1'b0, 32'd0, 32'd0);
`ifdef DMEM_ARB_PERF_CNT_EN
        chk("cnt_final", {16'd0, bus.conflict_cnt}, 32'd3);
`else
        chk("cnt_final", {16'd0, bus.conflict_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
